// File: rtl/serial_ripple_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_ripple_adder
// Function : Bit-serial A + B + Cin, one full adder and one carry flop, LSB
//            first, behind a start/busy/done handshake. SERIAL_SUB_EN adds a
//            'sub' input that turns the operation into A - B.
// Revision : 1.0 - initial release
// ============================================================================
module serial_ripple_adder #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_c,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out_s,
  output logic             out_c
);

  localparam int               c_cnt_w    = $clog2(WIDTH);
  localparam logic [c_cnt_w-1:0] c_last_idx = c_cnt_w'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [WIDTH-1:0]     sum_q;
  logic [WIDTH-1:0]     sum_d;
  logic                 carry_q;
  logic [c_cnt_w-1:0]   cnt_q;
  logic                 busy_q;
  logic                 done_q;
  logic [WIDTH-1:0]     out_s_q;
  logic                 out_c_q;

  logic                 w_sub;
  logic [WIDTH-1:0]     w_b_cap;
  logic                 w_c_cap;
  logic                 w_sum_bit;
  logic                 w_carry_nxt;

`ifdef SERIAL_SUB_EN
  assign w_sub = sub;
`else
  assign w_sub = 1'b0;
`endif

  // Subtraction is A + ~B + 1, so invert B and force the carry at capture.
  assign w_b_cap     = w_sub ? ~in_b : in_b;
  assign w_c_cap     = w_sub | in_c;

  assign w_sum_bit   = a_q[0] ^ b_q[0] ^ carry_q;
  assign w_carry_nxt = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
  assign sum_d       = {w_sum_bit, sum_q[WIDTH-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_s_q <= '0;
      out_c_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= in_a;
            b_q     <= w_b_cap;
            carry_q <= w_c_cap;
            sum_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          sum_q   <= sum_d;
          carry_q <= w_carry_nxt;
          cnt_q   <= cnt_q + c_cnt_w'(1);
          // Results are published only once the last bit is in.
          if (cnt_q == c_last_idx) begin
            out_s_q <= sum_d;
            out_c_q <= w_carry_nxt;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign out_s = out_s_q;
  assign out_c = out_c_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_ripple_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_ripple_adder
// Function : Directed, table-driven checks of serial_ripple_adder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_ripple_adder;

  localparam int WIDTH = 5;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c;
    logic             sb;
    logic [WIDTH-1:0] exp_s;
    logic             exp_c;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             in_c = 1'b0;
  logic             sub_r = 1'b0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out_s;
  logic             out_c;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] prev_s = '0;
  logic             prev_c = 1'b0;

  serial_ripple_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .in_a  (in_a),
    .in_b  (in_b),
    .in_c  (in_c),
`ifdef SERIAL_SUB_EN
    .sub   (sub_r),
`endif
    .busy  (busy),
    .done  (done),
    .out_s (out_s),
    .out_c (out_c)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation from IDLE; checks latency, busy, output hold, result.
  task automatic do_op(input vec_t v, input string name);
    int  n;
    bit  seen;
    bit  hold_ok;
    bit  busy_ok;
    in_a  = v.a;
    in_b  = v.b;
    in_c  = v.c;
    sub_r = v.sb;
    start = 1'b1;
    tick();
    start = 1'b0;
    in_a  = ~v.a;
    in_b  = ~v.b;
    in_c  = ~v.c;
    sub_r = ~v.sb;
    chk({name, " busy after start"}, int'(busy), 1);
    seen    = 1'b0;
    hold_ok = 1'b1;
    busy_ok = 1'b1;
    n       = 0;
    for (int i = 1; i <= 4 * WIDTH; i++) begin
      if (out_s !== prev_s || out_c !== prev_c) hold_ok = 1'b0;
      tick();
      if (done === 1'b1) begin
        n    = i;
        seen = 1'b1;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    chk({name, " done seen"}, int'(seen), 1);
    chk({name, " latency"}, n, WIDTH);
    chk({name, " busy during run"}, int'(busy_ok), 1);
    chk({name, " outputs held"}, int'(hold_ok), 1);
    chk({name, " busy at done"}, int'(busy), 0);
    chk({name, " out_s"}, int'(out_s), int'(v.exp_s));
    chk({name, " out_c"}, int'(out_c), int'(v.exp_c));
    prev_s = v.exp_s;
    prev_c = v.exp_c;
    tick();
    chk({name, " done one cycle"}, int'(done), 0);
  endtask

  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    vec_t vecs[$];
    int   n1;
    int   n2;

    vecs.push_back('{a: 5'd11, b: 5'd6,  c: 1'b0, sb: 1'b0, exp_s: 5'd17, exp_c: 1'b0});
    vecs.push_back('{a: 5'd31, b: 5'd1,  c: 1'b0, sb: 1'b0, exp_s: 5'd0,  exp_c: 1'b1});
    vecs.push_back('{a: 5'd31, b: 5'd31, c: 1'b1, sb: 1'b0, exp_s: 5'd31, exp_c: 1'b1});
    vecs.push_back('{a: 5'd0,  b: 5'd0,  c: 1'b1, sb: 1'b0, exp_s: 5'd1,  exp_c: 1'b0});
    vecs.push_back('{a: 5'd21, b: 5'd10, c: 1'b0, sb: 1'b0, exp_s: 5'd31, exp_c: 1'b0});
    vecs.push_back('{a: 5'd16, b: 5'd16, c: 1'b0, sb: 1'b0, exp_s: 5'd0,  exp_c: 1'b1});
`ifdef SERIAL_SUB_EN
    vecs.push_back('{a: 5'd11, b: 5'd6,  c: 1'b0, sb: 1'b1, exp_s: 5'd5,  exp_c: 1'b1});
    vecs.push_back('{a: 5'd6,  b: 5'd11, c: 1'b0, sb: 1'b1, exp_s: 5'd27, exp_c: 1'b0});
    vecs.push_back('{a: 5'd11, b: 5'd6,  c: 1'b1, sb: 1'b1, exp_s: 5'd5,  exp_c: 1'b1});
`endif

    // Reset state
    tick();
    tick();
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset out_s", int'(out_s), 0);
    chk("reset out_c", int'(out_c), 0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    foreach (vecs[i]) do_op(vecs[i], $sformatf("vec%0d", i));

    // start held high: inputs changed during RUN are ignored, one op per IDLE
    in_a  = 5'd3;
    in_b  = 5'd4;
    in_c  = 1'b0;
    sub_r = 1'b0;
    start = 1'b1;
    tick();
    in_a = 5'd9;
    in_b = 5'd9;
    wait_done(n1);
    chk("held first latency", n1, WIDTH);
    chk("held first out_s", int'(out_s), 7);
    chk("held first out_c", int'(out_c), 0);
    in_a = 5'd10;
    in_b = 5'd5;
    wait_done(n2);
    chk("held done spacing", n2, WIDTH + 2);
    chk("held second out_s", int'(out_s), 15);
    chk("held second out_c", int'(out_c), 0);
    start = 1'b0;
    tick();
    tick();
    chk("held back idle", int'(busy), 0);
    prev_s = 5'd15;
    prev_c = 1'b0;

    // Async reset mid-operation after a prior result of 17
    do_op('{a: 5'd11, b: 5'd6, c: 1'b0, sb: 1'b0, exp_s: 5'd17, exp_c: 1'b0}, "pre-reset");
    in_a  = 5'd11;
    in_b  = 5'd6;
    in_c  = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("async rst out_s", int'(out_s), 0);
    chk("async rst out_c", int'(out_c), 0);
    chk("async rst done", int'(done), 0);
    chk("async rst busy", int'(busy), 0);
    @(negedge clk);
    reset = 1'b0;
    prev_s = '0;
    prev_c = 1'b0;
    tick();
    do_op('{a: 5'd5, b: 5'd3, c: 1'b0, sb: 1'b0, exp_s: 5'd8, exp_c: 1'b0}, "post-reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
